// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 refill responder.
// States, address field widths and the fill pattern used for memory refills.
package l2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOOKUP   = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RESPOND  = 2'd3
    } l2_state_e;

    localparam int ADDR_W = 11;
    localparam int IDX_W  = 6;
    localparam int TAG_W  = 1;
    localparam int DATA_W = 32;

    localparam logic [15:0] FILL_PATTERN = 16'hCAFE;

    // Word returned by the backing memory for a line: pattern, zeros, line address, zero offset.
    function automatic logic [DATA_W-1:0] fill_word(input logic [ADDR_W-5:0] line_addr);
        return {FILL_PATTERN, 5'b00000, line_addr, 4'h0};
    endfunction

endpackage

// File: rtl/l2_tag_array.sv
// Direct-mapped valid/tag/data store for the L2 refill responder.
// One combinational lookup port, one write port; valid bits clear on reset.
// A write presented during reset is discarded so a dropped fill leaves no trace.
module l2_tag_array
    import l2_pkg::*;
#(
    parameter int NUM_LINES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [DATA_W-1:0]    data_r [NUM_LINES];

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

    // Valid bits: cleared by reset, set when a line is filled.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage: written only on a completed fill outside reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/l2_refill_responder.sv
// L2 refill responder: services one L1 miss refill at a time from a
// 64-line direct-mapped store, fetching from a fixed-latency backing memory on a miss.
// Optional hit/miss statistics counters are built when L2_STATS_EN is defined.
module l2_refill_responder
    import l2_pkg::*;
#(
    parameter int HIT_LATENCY = 2,
    parameter int MEM_LATENCY = 8,
    parameter int NUM_LINES   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int CNT_W = 16;

    l2_state_e          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ADDR_W-5:0]  line_r;      // latched addr[10:4]; offset bits are never needed

    logic               rd_valid_s;
    logic [TAG_W-1:0]   rd_tag_s;
    logic [DATA_W-1:0]  rd_data_s;
    logic               lookup_done_s;
    logic               lookup_hit_s;
    logic               fill_en_s;
    logic [DATA_W-1:0]  fill_data_s;

    assign lookup_done_s = (state_r == ST_LOOKUP) && (cnt_r == {CNT_W{1'b0}});
    assign lookup_hit_s  = rd_valid_s && (rd_tag_s == line_r[ADDR_W-5 -: TAG_W]);
    assign fill_en_s     = (state_r == ST_MEM_WAIT) && (cnt_r == {CNT_W{1'b0}});
    assign fill_data_s   = fill_word(line_r);

    l2_tag_array #(
        .NUM_LINES (NUM_LINES)
    ) u_tag_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (line_r[IDX_W-1:0]),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .wr_en    (fill_en_s),
        .wr_idx   (line_r[IDX_W-1:0]),
        .wr_tag   (line_r[ADDR_W-5 -: TAG_W]),
        .wr_data  (fill_data_s)
    );

    // Request/response FSM with latency counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            line_r     <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= {DATA_W{1'b0}};
            resp_hit   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        line_r    <= req_addr[ADDR_W-1:4];
                        cnt_r     <= CNT_W'(HIT_LATENCY - 1);
                        req_ready <= 1'b0;
                        state_r   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (lookup_hit_s) begin
                            resp_data  <= rd_data_s;
                            resp_hit   <= 1'b1;
                            resp_valid <= 1'b1;
                            state_r    <= ST_RESPOND;
                        end else begin
                            cnt_r   <= CNT_W'(MEM_LATENCY - 1);
                            state_r <= ST_MEM_WAIT;
                        end
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        resp_data  <= fill_data_s;
                        resp_hit   <= 1'b0;
                        resp_valid <= 1'b1;
                        state_r    <= ST_RESPOND;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_RESPOND: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef L2_STATS_EN
    logic [15:0] hit_cnt_r;
    logic [15:0] miss_cnt_r;

    // Saturating hit/miss counters stepped on each lookup decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_r  <= 16'h0000;
            miss_cnt_r <= 16'h0000;
        end else begin
            if (lookup_done_s && lookup_hit_s && (hit_cnt_r != 16'hFFFF)) begin
                hit_cnt_r <= hit_cnt_r + 16'd1;
            end
            if (lookup_done_s && !lookup_hit_s && (miss_cnt_r != 16'hFFFF)) begin
                miss_cnt_r <= miss_cnt_r + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_r;
    assign miss_count = miss_cnt_r;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_l2_refill_responder.sv
// Self-checking bench for l2_refill_responder: directed cases from the test plan
// plus randomized requests checked against a line-level reference model.
module tb_l2_refill_responder;

    localparam int HIT = 2;
    localparam int MEM = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_hit;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks   = 0;
    int failures = 0;

    bit mv [64];
    bit mt [64];
    int exp_hits   = 0;
    int exp_misses = 0;

    l2_refill_responder #(
        .HIT_LATENCY (HIT),
        .MEM_LATENCY (MEM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_hit   (resp_hit),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [10:0] a);
        return {16'hCAFE, 5'b00000, a[10:4], 4'h0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            mt[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Decide hit/miss from line contents, then install the line (fill or refresh).
    task automatic model_lookup(input logic [10:0] a, output bit hit);
        int idx;
        idx = int'(a[9:4]);
        hit = mv[idx] && (mt[idx] == a[10]);
        mv[idx] = 1'b1;
        mt[idx] = a[10];
        if (hit) exp_hits++;
        else exp_misses++;
    endtask

    task automatic check_stats();
`ifdef L2_STATS_EN
        check_val("hit_count", {16'h0, hit_count}, 32'(exp_hits));
        check_val("miss_count", {16'h0, miss_count}, 32'(exp_misses));
`else
        check_val("hit_count", {16'h0, hit_count}, 32'h0);
        check_val("miss_count", {16'h0, miss_count}, 32'h0);
`endif
    endtask

    // One full transaction: accept, measure latency, optional stall, handshake.
    task automatic do_req(input logic [10:0] a, input int stall, input bit early_ready);
        bit          hit;
        int          n;
        logic [31:0] d0;
        logic        h0;
        req_addr   = a;
        req_valid  = 1'b1;
        resp_ready = early_ready;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            check_val("accept_timeout", 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        model_lookup(a, hit);
        tick();
        req_valid = 1'b0;
        req_addr  = 11'($urandom);
        n = 0;
        while (!resp_valid && n < 100) begin
            if (req_ready !== 1'b0) check_val("req_ready_busy", 32'(req_ready), 32'h0);
            tick();
            n++;
        end
        check_val("latency", 32'(n), hit ? 32'(HIT) : 32'(HIT + MEM));
        check_val("resp_data", resp_data, exp_word(a));
        check_val("resp_hit", 32'(resp_hit), 32'(hit));
        check_stats();
        d0 = resp_data;
        h0 = resp_hit;
        if (!early_ready) begin
            for (int i = 0; i < stall; i++) begin
                tick();
                check_val("stall_valid", 32'(resp_valid), 32'h1);
                check_val("stall_data", resp_data, d0);
                check_val("stall_hit", 32'(resp_hit), 32'(h0));
                check_val("stall_req_ready", 32'(req_ready), 32'h0);
            end
            resp_ready = 1'b1;
        end
        tick();
        resp_ready = 1'b0;
        check_val("post_hs_valid", 32'(resp_valid), 32'h0);
        check_val("post_hs_req_ready", 32'(req_ready), 32'h1);
    endtask

    initial begin
        int          outstanding;
        int          resps;
        bit          acc;
        bit          hs;
        bit          hit;
        bit          seen;
        logic [10:0] a;
        logic [31:0] qd [$];
        bit          qh [$];

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 11'h000;
        resp_ready = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_req_ready", 32'(req_ready), 32'h1);
        check_val("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_val("rst_resp_data", resp_data, 32'h0);
        check_val("rst_resp_hit", 32'(resp_hit), 32'h0);
        check_stats();

        // Directed test plan sequence.
        do_req(11'h234, 0, 1'b0);
        do_req(11'h23C, 0, 1'b0);
        do_req(11'h634, 0, 1'b0);
        do_req(11'h234, 0, 1'b0);
        do_req(11'h7F5, 5, 1'b0);
        check_val("plan_7f5_data", resp_data, 32'hCAFE07F0);

        // Reset in the middle of a memory fetch drops the request and the fill.
        req_addr  = 11'h100;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (HIT + 3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) seen = 1'b1;
            tick();
        end
        check_val("mid_reset_no_resp", 32'(seen), 32'h0);
        check_val("mid_reset_req_ready", 32'(req_ready), 32'h1);
        check_stats();
        do_req(11'h100, 0, 1'b0);

        // Randomized requests over a few indices so hits, misses and evictions all occur.
        for (int i = 0; i < 40; i++) begin
            a = 11'($urandom);
            a[9:6] = 4'h0;
            do_req(a, int'($urandom_range(0, 3)), 1'(($urandom & 32'h1)));
        end

        // Back-to-back: req_valid held high, one acceptance per response handshake.
        outstanding = 0;
        resps       = 0;
        req_valid   = 1'b1;
        resp_ready  = 1'b1;
        for (int c = 0; c < 400 && resps < 12; c++) begin
            a = 11'($urandom);
            a[9:6] = 4'h0;
            req_addr = a;
            acc = req_valid && req_ready;
            hs  = resp_valid && resp_ready;
            if (hs) begin
                if (qd.size() == 0) begin
                    check_val("b2b_unexpected_resp", 32'h1, 32'h0);
                end else begin
                    check_val("b2b_data", resp_data, qd.pop_front());
                    check_val("b2b_hit", 32'(resp_hit), 32'(qh.pop_front()));
                end
                resps++;
            end
            if (acc) begin
                model_lookup(a, hit);
                qd.push_back(exp_word(a));
                qh.push_back(hit);
            end
            tick();
            if (acc) outstanding++;
            if (hs) outstanding--;
            check_val("b2b_one_outstanding", 32'(outstanding <= 1), 32'h1);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        check_val("b2b_resp_count", 32'(resps >= 12), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
